// File: rtl/l2_conv.sv
// Second convolution stage: 18-tap serial MAC over a captured two-channel 3x3 window,
// then normalise and saturate to 18 bits. Define L2_RELU_EN to clamp negative results to zero.
module l2_conv #(
    parameter int unsigned N_OUT = 121,
    parameter int unsigned FRAC  = 8,
    parameter int unsigned ACC_W = 42
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               rd_i,
    input  logic signed [17:0] win_i [18],
    input  logic               tx_done_i,
    input  logic               w_wr_i,
    input  logic [4:0]         w_addr_i,
    input  logic signed [17:0] w_din_i,
    output logic               addr_rd_inc_o,
    output logic               busy_o,
    output logic signed [17:0] dout_o,
    output logic               dout_vld_o,
    output logic               done_o
);

    localparam int unsigned CntW = (N_OUT > 1) ? $clog2(N_OUT) : 1;
    localparam logic signed [ACC_W-1:0] SatMax = {{(ACC_W-18){1'b0}}, 18'h1FFFF};
    localparam logic signed [ACC_W-1:0] SatMin = {{(ACC_W-18){1'b1}}, 18'h20000};

    typedef enum logic [1:0] {StIdle, StMac, StNorm} state_e;

    state_e                   state_q, state_d;
    logic [4:0]               k_q, k_d;
    logic [CntW-1:0]          cnt_q, cnt_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic signed [17:0]       win_q [18];
    logic signed [17:0]       win_d [18];
    logic signed [17:0]       w_q [19];
    logic signed [17:0]       w_d [19];
    logic signed [17:0]       dout_q, dout_d;
    logic                     dout_vld_q, dout_vld_d;
    logic                     done_q, done_d;
    logic                     inc_q, inc_d;

    logic signed [35:0]       prod;
    logic signed [ACC_W-1:0]  prod_ext;
    logic signed [ACC_W-1:0]  bias_ext;
    logic signed [ACC_W-1:0]  shr;
    logic signed [17:0]       sat_r;
    logic signed [17:0]       res;

    always_comb begin
        prod     = win_q[k_q] * w_q[k_q];
        prod_ext = {{(ACC_W-36){prod[35]}}, prod};
        bias_ext = {{(ACC_W-18){w_q[18][17]}}, w_q[18]};
        shr      = acc_q >>> FRAC;
        if (shr > SatMax) begin
            sat_r = 18'sh1FFFF;
        end else if (shr < SatMin) begin
            sat_r = 18'sh20000;
        end else begin
            sat_r = shr[17:0];
        end
`ifdef L2_RELU_EN
        res = sat_r[17] ? 18'sd0 : sat_r;
`else
        res = sat_r;
`endif
    end

    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        win_d      = win_q;
        w_d        = w_q;
        dout_d     = dout_q;
        dout_vld_d = 1'b0;
        done_d     = 1'b0;
        inc_d      = 1'b0;

        // Weights only move while idle; a capture on the same edge still sees the old bias.
        if (w_wr_i && (state_q == StIdle) && (w_addr_i <= 5'd18)) begin
            w_d[w_addr_i] = w_din_i;
        end

        if (tx_done_i) begin
            state_d = StIdle;
            k_d     = 5'd0;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (rd_i) begin
                        win_d   = win_i;
                        acc_d   = bias_ext <<< FRAC;
                        k_d     = 5'd0;
                        inc_d   = 1'b1;
                        state_d = StMac;
                    end
                end
                StMac: begin
                    acc_d = acc_q + prod_ext;
                    if (k_q == 5'd17) begin
                        state_d = StNorm;
                    end else begin
                        k_d = k_q + 5'd1;
                    end
                end
                StNorm: begin
                    dout_d     = res;
                    dout_vld_d = 1'b1;
                    if (cnt_q == CntW'(N_OUT - 1)) begin
                        done_d = 1'b1;
                        cnt_d  = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                    state_d = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            k_q        <= 5'd0;
            cnt_q      <= '0;
            acc_q      <= '0;
            win_q      <= '{default: '0};
            w_q        <= '{default: '0};
            dout_q     <= '0;
            dout_vld_q <= 1'b0;
            done_q     <= 1'b0;
            inc_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            win_q      <= win_d;
            w_q        <= w_d;
            dout_q     <= dout_d;
            dout_vld_q <= dout_vld_d;
            done_q     <= done_d;
            inc_q      <= inc_d;
        end
    end

    assign addr_rd_inc_o = inc_q;
    assign busy_o        = (state_q != StIdle);
    assign dout_o        = dout_q;
    assign dout_vld_o    = dout_vld_q;
    assign done_o        = done_q;

endmodule

// File: tb/tb_l2_conv.sv
// Directed bench for l2_conv with a three-window frame; expected results hand-computed.
module tb_l2_conv;

    localparam int unsigned NOut = 3;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               rd;
    logic signed [17:0] win [18];
    logic               tx_done;
    logic               w_wr;
    logic [4:0]         w_addr;
    logic signed [17:0] w_din;
    logic               addr_rd_inc;
    logic               busy;
    logic signed [17:0] dout;
    logic               dout_vld;
    logic               done;

    int n_checks = 0;
    int n_fail   = 0;
    int frame_pos = 0;

    always #5 clk = ~clk;

    l2_conv #(.N_OUT(NOut), .FRAC(8), .ACC_W(42)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .rd_i          (rd),
        .win_i         (win),
        .tx_done_i     (tx_done),
        .w_wr_i        (w_wr),
        .w_addr_i      (w_addr),
        .w_din_i       (w_din),
        .addr_rd_inc_o (addr_rd_inc),
        .busy_o        (busy),
        .dout_o        (dout),
        .dout_vld_o    (dout_vld),
        .done_o        (done)
    );

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic write_w(input int addr, input int data);
        @(negedge clk);
        w_wr   = 1'b1;
        w_addr = 5'(addr);
        w_din  = 18'(data);
        @(negedge clk);
        w_wr   = 1'b0;
    endtask

    task automatic load_all(input int wval, input int bias);
        for (int i = 0; i < 18; i++) write_w(i, wval);
        write_w(18, bias);
    endtask

    task automatic set_win(input int tap);
        for (int i = 0; i < 18; i++) win[i] = 18'(tap);
    endtask

    task automatic pulse_abort();
        @(negedge clk);
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
        frame_pos = 0;
    endtask

    // One window; optionally attempts weight writes mid-MAC that must be ignored.
    task automatic run_window(input string tag, input int tap, input int exp_res,
                              input bit mac_writes);
        int lat;
        int incs;
        int res;
        int dn;
        bit exp_done;
        @(negedge clk);
        set_win(tap);
        rd = 1'b1;
        @(posedge clk);
        #1;
        rd = 1'b0;
        set_win(12345);
        incs = int'(addr_rd_inc);
        lat = -1;
        res = 0;
        dn = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            incs += int'(addr_rd_inc);
            if (mac_writes && i == 3) begin
                w_wr = 1'b1; w_addr = 5'd18; w_din = 18'sd1000;
            end else if (mac_writes && i == 4) begin
                w_addr = 5'd5; w_din = 18'sd0;
            end else if (i == 5) begin
                w_wr = 1'b0;
            end
            if (dout_vld) begin
                lat = i;
                res = int'(dout);
                dn = int'(done);
                break;
            end
        end
        exp_done = (frame_pos == NOut - 1);
        frame_pos = exp_done ? 0 : frame_pos + 1;
        check({tag, "_dout"}, res, exp_res);
        check({tag, "_latency"}, lat, 19);
        check({tag, "_rdinc"}, incs, 1);
        check({tag, "_done"}, dn, int'(exp_done));
    endtask

    initial begin
        int t_vld [4];
        int d_vld [4];
        int nv;
        int vsum;
        int exp_sat_neg;
        int exp_neg;
`ifdef L2_RELU_EN
        exp_sat_neg = 0;
        exp_neg = 0;
`else
        exp_sat_neg = -131072;
        exp_neg = -90;
`endif
        rst_n = 1'b0;
        rd = 1'b0;
        tx_done = 1'b0;
        w_wr = 1'b0;
        w_addr = 5'd0;
        w_din = 18'sd0;
        set_win(0);
        #23;
        check("rst_dout", int'(dout), 0);
        check("rst_vld", int'(dout_vld), 0);
        check("rst_done", int'(done), 0);
        check("rst_rdinc", int'(addr_rd_inc), 0);
        check("rst_busy", int'(busy), 0);
        @(negedge clk);
        rst_n = 1'b1;

        load_all(256, 0);
        run_window("unity", 10, 180, 1'b0);
        repeat (3) @(negedge clk);
        check("hold_dout", int'(dout), 180);
        check("hold_vld", int'(dout_vld), 0);

        load_all(0, 7);
        run_window("bias", 1234, 7, 1'b0);

        load_all(131071, 0);
        run_window("sat_pos", 131071, 131071, 1'b0);
        run_window("sat_neg", -131072, exp_sat_neg, 1'b0);

        load_all(-256, 0);
        run_window("neg", 5, exp_neg, 1'b0);

        load_all(256, 0);
        write_w(19, 5000);
        write_w(31, 5000);
        run_window("bad_addr", 10, 180, 1'b0);

        // Frame counting with rd held high across four windows.
        pulse_abort();
        set_win(1);
        rd = 1'b1;
        nv = 0;
        for (int i = 0; i < 120 && nv < 4; i++) begin
            @(posedge clk);
            #1;
            if (dout_vld) begin
                t_vld[nv] = i;
                d_vld[nv] = int'(done);
                if (nv == 0) check("frame_dout", int'(dout), 18);
                nv++;
                if (nv == 4) rd = 1'b0;
            end
        end
        rd = 1'b0;
        check("frame_count", nv, 4);
        if (nv == 4) begin
            check("frame_first", t_vld[0], 19);
            check("frame_gap1", t_vld[1] - t_vld[0], 20);
            check("frame_gap2", t_vld[2] - t_vld[1], 20);
            check("frame_gap3", t_vld[3] - t_vld[2], 20);
            check("frame_done0", d_vld[0], 0);
            check("frame_done1", d_vld[1], 0);
            check("frame_done2", d_vld[2], 1);
            check("frame_done3", d_vld[3], 0);
        end
        repeat (2) @(negedge clk);
        check("frame_idle", int'(busy), 0);

        // Abort at k=9: no result, dout retained, frame count restarts.
        @(negedge clk);
        set_win(10);
        rd = 1'b1;
        @(posedge clk);
        #1;
        rd = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        tx_done = 1'b1;
        @(posedge clk);
        #1;
        tx_done = 1'b0;
        check("abort_busy", int'(busy), 0);
        vsum = 0;
        for (int i = 0; i < 25; i++) begin
            @(posedge clk);
            #1;
            vsum += int'(dout_vld);
        end
        check("abort_novld", vsum, 0);
        check("abort_dout", int'(dout), 18);
        frame_pos = 0;
        run_window("post_abort0", 10, 180, 1'b0);
        run_window("lockout", 10, 180, 1'b1);
        run_window("post_abort2", 10, 180, 1'b0);

        // Asynchronous reset mid-MAC clears outputs and weights.
        @(negedge clk);
        set_win(10);
        rd = 1'b1;
        @(posedge clk);
        #1;
        rd = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_dout", int'(dout), 0);
        check("arst_busy", int'(busy), 0);
        check("arst_vld", int'(dout_vld), 0);
        @(negedge clk);
        rst_n = 1'b1;
        frame_pos = 0;
        run_window("arst_wclr", 10, 0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/l2_conv.md
Name: l2_conv

Overview:
- Second convolution stage; sits directly downstream of the layer-1 max-pool/window RAM.
- Takes one 18-tap window per transaction: two 3x3 channels, 18 x 18-bit signed values, presented in parallel while rd is high.
- Runs a sequential multiply-accumulate (one 18x18 multiplier, one tap per cycle) against a loadable weight/bias register file.
- Normalises, saturates and emits one 18-bit result per window. Pulses addr_rd_inc to advance the upstream read address.

Parameters:
- N_OUT, 121, windows per frame; done pulses on the last one.
- FRAC, 8, fractional bits of weights (Q.FRAC); accumulator is arithmetically shifted right by FRAC before saturation.
- ACC_W, 42, accumulator width in bits; must be at least 41.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- rd  in  1  upstream window valid.
- win  in  18 x 18 (unpacked [17:0], signed)  window taps; index 0..8 = channel 0, 9..17 = channel 1.
- tx_done  in  1  synchronous frame abort/clear.
- w_wr  in  1  weight write strobe.
- w_addr  in  5  weight address: 0..17 = tap weights, 18 = bias.
- w_din  in  18 signed  weight/bias data.
- addr_rd_inc  out  1  one-cycle pulse; upstream advances its read address.
- busy  out  1  high while not in IDLE.
- dout  out  18 signed  result.
- dout_vld  out  1  one-cycle result strobe.
- done  out  1  one-cycle pulse coincident with the N_OUT-th dout_vld.

Behaviour:
- Reset (asynchronous):
  - state = IDLE, tap counter k = 0, window counter cnt = 0.
  - dout = 0; dout_vld, done, addr_rd_inc, busy = 0.
  - All 19 weight registers = 0.
- States: IDLE, MAC, NORM.
- IDLE: on an edge with rd=1 and tx_done=0:
  - win_q <= win (all 18 taps captured; win may change afterwards).
  - acc <= bias sign-extended to ACC_W, then shifted left by FRAC.
  - k <= 0; addr_rd_inc <= 1 for exactly one cycle; state <= MAC.
- MAC: each edge, acc <= acc + win_q[k]*w[k], where the product is a full 36-bit signed value sign-extended to ACC_W. When k == 17, state <= NORM; otherwise k <= k+1. Exactly 18 edges.
- NORM: one edge:
  - r = acc >>> FRAC, saturated to [-131072, 131071].
  - dout <= r; dout_vld <= 1 for one cycle.
  - If cnt == N_OUT-1: done <= 1 and cnt <= 0; else cnt <= cnt+1.
  - state <= IDLE.
- Timing:
  - Capture edge E0; dout_vld is high in the cycle after edge E19.
  - Minimum window period is 20 cycles; back-to-back capture is allowed on the edge following NORM if rd=1.
- dout holds its value between strobes.
- Weight writes:
  - Accepted only when busy=0; ignored while busy.
  - Writes to w_addr > 18 are ignored.
  - A write and a capture on the same edge: the capture uses the old values; the write still lands.
- tx_done (synchronous, highest priority after reset):
  - state <= IDLE; k, cnt <= 0.
  - dout_vld, done, addr_rd_inc <= 0; any in-flight result is discarded.
  - Weights and dout are retained. rd is ignored on that edge.
- rd is sampled only in IDLE; rd held high with no new data is the upstream's responsibility.

Optional Feature:
- L2_RELU_EN defined: after saturation, negative r is replaced by 0, so dout is in [0, 131071].
- Not defined: the signed saturated value passes unchanged.
- Timing is identical in both builds.

Test Plan:
- Unity weights, no bias: w[0..17] = 256, bias = 0, FRAC = 8, all taps = 10 -> single addr_rd_inc pulse the cycle after capture; dout = 180, dout_vld exactly 19 cycles after the capture edge.
- Bias only: all weights 0, bias = 7, any window -> dout = 7.
- Saturation: all w = 131071, all taps = 131071 -> dout = 131071. Then all taps = -131072 -> dout = -131072 without L2_RELU_EN, 0 with it.
- Negative result: w = -256, taps = 5 -> dout = -90 (0x3FFA6) without L2_RELU_EN; 0 with it.
- Frame count: N_OUT = 3, rd held high -> three dout_vld pulses 20 cycles apart; done only with the third; a fourth window restarts the count (no done).
- Abort and write lockout:
  - tx_done asserted at MAC k=9 -> no dout_vld, busy=0 next cycle, cnt=0.
  - w_wr during MAC is ignored (verify by readback result).
  - rst_n low mid-MAC -> all outputs 0 immediately; weights cleared.
